// File: rtl/m20k_burst_initiator.sv
// Burst initiator for one port of an M20K-style synchronous RAM (1-cycle read latency).
// Write bursts come from a valid/ready stream; read bursts go out through a 2-entry skid FIFO.
module m20k_burst_initiator #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  output logic              CE,
  output logic              WE,
  output logic [DATA_W-1:0] WEM,
  input  logic [DATA_W-1:0] Q
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] count_q;
  logic              inflight_q;
  logic              done_q;

  logic [DATA_W-1:0] fifo_q [2];
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        occ_q;

  logic              wr_accept;
  logic              pop;
  logic              rd_issue;
  logic [2:0]        outstanding;

  always_comb begin
    wr_accept   = (state_q == StWrite) && wr_valid;
    rd_valid    = (occ_q != 2'd0);
    pop         = rd_valid && rd_ready;
    outstanding = {1'b0, occ_q} + {2'b00, inflight_q};
    // A slot freed by this cycle's pop can be refilled by this cycle's issue.
    rd_issue    = (state_q == StRead) && (outstanding < (3'd2 + {2'b00, pop}));
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign wr_ready  = (state_q == StWrite);
  assign done      = done_q;
  assign A         = addr_q;
  assign D         = wr_accept ? wr_data : '0;
  assign CE        = wr_accept || rd_issue;
  assign WE        = wr_accept;
  assign WEM       = '1;
  assign rd_data   = fifo_q[rd_ptr_q];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= rd_issue;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            addr_q  <= cmd_addr;
            count_q <= cmd_len;
            state_q <= cmd_write ? StWrite : StRead;
          end
        end
        StWrite: begin
          if (wr_accept) begin
            addr_q  <= addr_q + ADDR_W'(1);
            count_q <= count_q - ADDR_W'(1);
            if (count_q == '0) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end
          end
        end
        StRead: begin
          if (rd_issue) begin
            addr_q  <= addr_q + ADDR_W'(1);
            count_q <= count_q - ADDR_W'(1);
            if (count_q == '0) begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if ((occ_q == 2'd0) && !inflight_q) begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The issue rule keeps occupancy plus in-flight at or below two, so a push never overflows.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= Q;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

endmodule
